onehot_decode_dispatch: RTL and testbench

//   Inverse of the 8-to-3 priority encoder. Accepts encoded line indices (plus a "none" flag) over a

---
 rtl/onehot_decode_dispatch_pkg.sv | 24 ++
 rtl/onehot_decode_dispatch_if.sv | 25 ++
 rtl/onehot_decode_dispatch_sync_fifo.sv | 63 ++++++
 rtl/onehot_decode_dispatch.sv | 79 +++++++
 tb/tb_onehot_decode_dispatch.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_decode_dispatch_pkg.sv
// rtl/onehot_decode_dispatch_pkg.sv - shared widths, beat type and one-hot mapping
package onehot_decode_dispatch_pkg;

   localparam int DEF_CODE_W = 3;
   localparam int DEF_OUT_W  = 2 ** DEF_CODE_W;
   localparam int DEF_DEPTH  = 4;
   localparam int PTR_W      = $clog2(DEF_DEPTH);
   localparam int LVL_W      = PTR_W + 1;

   typedef struct packed {
      logic                  none;
      logic [DEF_CODE_W-1:0] code;
   } beat_t;

   // OUT_W-1-code equals the bitwise inverse of code because OUT_W is a power of two
   function automatic logic [DEF_OUT_W-1:0] onehot_map(input logic [DEF_CODE_W-1:0] code,
                                                       input logic reverse);
      logic [DEF_CODE_W-1:0] idx;
      idx = reverse ? ~code : code;
      onehot_map      = '0;
      onehot_map[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/onehot_decode_dispatch_if.sv
// rtl/onehot_decode_dispatch_if.sv - input beat and decoded-vector handshake bundle
interface onehot_decode_dispatch_if;
   import onehot_decode_dispatch_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [DEF_CODE_W-1:0] in_code;
   logic                  in_none;
   logic                  out_valid;
   logic                  out_ready;
   logic [DEF_OUT_W-1:0]  out_onehot;
   logic                  out_none;
   logic [LVL_W-1:0]      level;

   modport master (
      output in_valid, in_code, in_none, out_ready,
      input  in_ready, out_valid, out_onehot, out_none, level
   );

   modport slave (
      input  in_valid, in_code, in_none, out_ready,
      output in_ready, out_valid, out_onehot, out_none, level
   );

endinterface

// File: rtl/onehot_decode_dispatch_sync_fifo.sv
// rtl/onehot_decode_dispatch_sync_fifo.sv - power-of-two synchronous FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   // full blocks a push even when a pop happens on the same edge
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rptr_q];

   // next pointers wrap naturally at DEPTH; occupancy moves only on push xor pop
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop) level_d = level_q + (AW+1)'(1);
      if (do_pop && !do_push) level_d = level_q - (AW+1)'(1);
   end

   // pointer and occupancy registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/onehot_decode_dispatch.sv
// rtl/onehot_decode_dispatch.sv - buffers encoded indices and issues registered one-hot vectors
module onehot_decode_dispatch
   import onehot_decode_dispatch_pkg::*;
#(
   parameter bit REVERSE = 1'b0
) (
   input logic                     clk,
   input logic                     rst,
   onehot_decode_dispatch_if.slave bus
);
   beat_t                fifo_wdata;
   logic [$bits(beat_t)-1:0] fifo_rdata_raw;
   beat_t                fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [LVL_W-1:0]     fifo_level;
   logic                 load;
   logic [DEF_OUT_W-1:0] dec_vec;
   logic                 valid_q, valid_d;
   logic                 none_q, none_d;
   logic [DEF_OUT_W-1:0] onehot_q, onehot_d;

   assign fifo_wdata = '{none: bus.in_none, code: bus.in_code};
   assign fifo_rdata = beat_t'(fifo_rdata_raw);

   // the output register refills whenever it is empty or being drained; that edge also pops
   assign load = !fifo_empty && (!valid_q || bus.out_ready);

   sync_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (DEF_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.in_valid),
      .wdata_i (fifo_wdata),
      .pop_i   (load),
      .rdata_o (fifo_rdata_raw),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign dec_vec = fifo_rdata.none ? '0 : onehot_map(fifo_rdata.code, REVERSE);

   // output stage next state: load a decoded beat, or drop valid once the consumer takes it
   always_comb begin
      valid_d  = valid_q;
      none_d   = none_q;
      onehot_d = onehot_q;
      if (load) begin
         valid_d  = 1'b1;
         none_d   = fifo_rdata.none;
         onehot_d = dec_vec;
      end else if (bus.out_ready) begin
         valid_d  = 1'b0;
      end
   end

   // output register; holds steady while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         none_q   <= 1'b0;
         onehot_q <= '0;
      end else begin
         valid_q  <= valid_d;
         none_q   <= none_d;
         onehot_q <= onehot_d;
      end
   end

   assign bus.in_ready   = !fifo_full;
   assign bus.out_valid  = valid_q;
   assign bus.out_none   = none_q;
   assign bus.out_onehot = onehot_q;
   assign bus.level      = fifo_level;

endmodule

// File: tb/tb_onehot_decode_dispatch.sv
// tb/tb_onehot_decode_dispatch.sv - scoreboard bench for both index mappings
module tb_onehot_decode_dispatch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   onehot_decode_dispatch_if b0 ();
   onehot_decode_dispatch_if b1 ();

   onehot_decode_dispatch #(.REVERSE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   onehot_decode_dispatch #(.REVERSE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   int total = 0;
   int bad = 0;
   int pushes = 0;
   int pops = 0;
   int cyc = 0;
   bit rand_rdy = 1'b0;
   logic [3:0] exp_q [$];

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endfunction

   // reference: line index is the code, or mirrored for the MSB-first mapping
   function automatic logic [7:0] model_vec(input int code, input bit none, input bit rev);
      int idx;
      if (none) return 8'h00;
      idx = rev ? (7 - code) : code;
      return 8'(2 ** idx);
   endfunction

   task automatic drive_in(input logic v, input logic [2:0] c, input logic n);
      b0.in_valid = v; b0.in_code = c; b0.in_none = n;
      b1.in_valid = v; b1.in_code = c; b1.in_none = n;
   endtask

   task automatic drive_rdy(input logic r);
      b0.out_ready = r;
      b1.out_ready = r;
   endtask

   task automatic push_beat(input int c, input bit n);
      bit acc;
      int k;
      drive_in(1'b1, 3'(c), n);
      acc = 1'b0;
      k = 0;
      while (!acc && k < 200) begin
         @(negedge clk);
         acc = b0.in_ready;
         @(posedge clk);
         #1;
         k++;
      end
      if (!acc) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_valid();
      int k;
      k = 0;
      while (!b0.out_valid && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("wait_valid_timeout", b0.out_valid, 1);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || b0.out_valid) && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic single(input int c, input bit n, input logic [7:0] e0, input logic [7:0] e1);
      push_beat(c, n);
      drive_in(1'b0, 3'd0, 1'b0);
      wait_valid();
      chk("single_vec_fwd", b0.out_onehot, e0);
      chk("single_vec_rev", b1.out_onehot, e1);
      chk("single_none", b1.out_none, n);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         drive_rdy(1'($urandom_range(0, 1)));
      end
   end

   // monitor: check each accepted output against the queued expectation, record accepted inputs
   logic       prev_stall = 1'b0;
   logic [7:0] prev_vec = 8'h00;
   logic       prev_none = 1'b0;
   always @(negedge clk) begin
      logic [3:0] e;
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
         pushes = 0;
         pops = 0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", b0.out_valid, 1);
            chk("hold_vec", b0.out_onehot, prev_vec);
            chk("hold_none", b0.out_none, prev_none);
         end
         if (b0.out_valid && b0.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               pops++;
               chk("sb_vec_fwd", b0.out_onehot, model_vec(int'(e[2:0]), e[3], 1'b0));
               chk("sb_vec_rev", b1.out_onehot, model_vec(int'(e[2:0]), e[3], 1'b1));
               chk("sb_none", b0.out_none, e[3]);
               chk("sb_none_rev", b1.out_none, e[3]);
               chk("sb_valid_rev", b1.out_valid, 1);
               chk("sb_onehot_bits", $countones(b0.out_onehot), e[3] ? 0 : 1);
            end
         end
         if (b0.in_valid && b0.in_ready) begin
            exp_q.push_back({b0.in_none, b0.in_code});
            pushes++;
         end
         prev_stall = b0.out_valid && !b0.out_ready;
         prev_vec   = b0.out_onehot;
         prev_none  = b0.out_none;
      end
   end

   initial begin
      int t0;
      drive_in(1'b0, 3'd0, 1'b0);
      drive_rdy(1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", b0.out_valid, 0);
      chk("rst_onehot", b0.out_onehot, 0);
      chk("rst_none", b0.out_none, 0);
      chk("rst_level", b0.level, 0);
      chk("rst_in_ready", b0.in_ready, 1);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single beat latency, forward mapping
      drive_rdy(1'b1);
      push_beat(5, 1'b0);
      drive_in(1'b0, 3'd0, 1'b0);
      chk("lat_not_early", b0.out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_valid", b0.out_valid, 1);
      chk("lat_vec_fwd", b0.out_onehot, 8'h20);
      chk("lat_vec_rev", b1.out_onehot, 8'h04);
      @(posedge clk);
      #1;

      // mapping corners and the none flag
      single(0, 1'b0, 8'h01, 8'h80);
      single(7, 1'b0, 8'h80, 8'h01);
      single(3, 1'b1, 8'h00, 8'h00);

      // backpressure: one beat in the output register, four in the FIFO
      drive_rdy(1'b0);
      for (int i = 0; i < 5; i++) push_beat(i, 1'b0);
      chk("bp_level", b0.level, 4);
      chk("bp_in_ready", b0.in_ready, 0);
      chk("bp_out_valid", b0.out_valid, 1);
      chk("bp_out_vec", b0.out_onehot, 8'h01);
      drive_in(1'b1, 3'd5, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_held_ready", b0.in_ready, 0);
      chk("bp_held_level", b0.level, 4);
      drive_rdy(1'b1);
      push_beat(5, 1'b0);
      drive_in(1'b0, 3'd0, 1'b0);
      drain();

      // streaming, one beat per cycle
      drive_rdy(1'b1);
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         push_beat(i, 1'b0);
         chk("stream_level", 32'(b0.level <= 1), 1);
      end
      chk("stream_cycles", cyc - t0, 8);
      drive_in(1'b0, 3'd0, 1'b0);
      drain();

      // randomized traffic
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            drive_in(1'b0, 3'd0, 1'b0);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         push_beat(int'($urandom_range(0, 7)), $urandom_range(0, 4) == 0);
      end
      drive_in(1'b0, 3'd0, 1'b0);
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      drive_rdy(1'b1);
      drain();
      chk("rand_pops_eq_pushes", pops, pushes);

      // reset mid-run with three beats queued
      drive_rdy(1'b0);
      for (int i = 0; i < 3; i++) push_beat(i + 2, 1'b0);
      drive_in(1'b0, 3'd0, 1'b0);
      chk("pre_rst_valid", b0.out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", b0.out_valid, 0);
      chk("mid_rst_onehot", b0.out_onehot, 0);
      chk("mid_rst_level", b0.level, 0);
      chk("mid_rst_in_ready", b0.in_ready, 1);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_valid", b0.out_valid, 0);
      drive_rdy(1'b1);
      single(6, 1'b0, 8'h40, 8'h02);
      drain();
      chk("final_pops_eq_pushes", pops, pushes);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
